// File: rtl/bp_me_cache_dma_mux.sv
// Merges per-bank L2 cache DMA channels onto one memory-side DMA channel.
// Round-robin packet grants, write data locked to one bank per block, read returns steered by a bank-ID FIFO.
module bp_me_cache_dma_mux #(
   parameter int num_banks_p            = 2,
   parameter int daddr_width_p          = 28,
   parameter int fill_width_p           = 64,
   parameter int block_size_in_fills_p  = 8,
   parameter int reads_outstanding_p    = 4,
   localparam int dma_pkt_width_lp      = daddr_width_p + 1
) (
   input  logic                                   clk_i,
   input  logic                                   reset_n_i,

   input  logic [num_banks_p*dma_pkt_width_lp-1:0] bank_dma_pkt_i,
   input  logic [num_banks_p-1:0]                  bank_dma_pkt_v_i,
   output logic [num_banks_p-1:0]                  bank_dma_pkt_ready_and_o,

   output logic [num_banks_p*fill_width_p-1:0]     bank_dma_data_o,
   output logic [num_banks_p-1:0]                  bank_dma_data_v_o,
   input  logic [num_banks_p-1:0]                  bank_dma_data_ready_and_i,

   input  logic [num_banks_p*fill_width_p-1:0]     bank_dma_data_i,
   input  logic [num_banks_p-1:0]                  bank_dma_data_v_i,
   output logic [num_banks_p-1:0]                  bank_dma_data_ready_and_o,

   output logic [dma_pkt_width_lp-1:0]             mem_dma_pkt_o,
   output logic                                    mem_dma_pkt_v_o,
   input  logic                                    mem_dma_pkt_ready_and_i,

   input  logic [fill_width_p-1:0]                 mem_dma_data_i,
   input  logic                                    mem_dma_data_v_i,
   output logic                                    mem_dma_data_ready_and_o,

   output logic [fill_width_p-1:0]                 mem_dma_data_o,
   output logic                                    mem_dma_data_v_o,
   input  logic                                    mem_dma_data_ready_and_i
);

   localparam int bank_id_w_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
   localparam int idx_w_lp     = bank_id_w_lp + 1;
   localparam int cnt_w_lp     = $clog2(block_size_in_fills_p);
   localparam int ptr_w_lp     = (reads_outstanding_p > 1) ? $clog2(reads_outstanding_p) : 1;
   localparam int occ_w_lp     = $clog2(reads_outstanding_p + 1);

   typedef enum logic {e_ready = 1'b0, e_write = 1'b1} state_e;

   state_e                    r_state;
   logic [bank_id_w_lp-1:0]   r_rr_ptr;
   logic [bank_id_w_lp-1:0]   r_wr_bank;
   logic [cnt_w_lp-1:0]       r_wr_cnt;
   logic [cnt_w_lp-1:0]       r_rd_cnt;
   logic [bank_id_w_lp-1:0]   r_fifo [reads_outstanding_p];
   logic [ptr_w_lp-1:0]       r_fifo_wptr;
   logic [ptr_w_lp-1:0]       r_fifo_rptr;
   logic [occ_w_lp-1:0]       r_fifo_occ;

   logic [dma_pkt_width_lp-1:0] w_pkt [num_banks_p];
   logic [num_banks_p-1:0]      w_elig;
   logic                        w_gnt_v;
   logic [bank_id_w_lp-1:0]     w_gnt_id;
   logic                        w_gnt_write;
   logic                        w_pkt_hs;
   logic                        w_full;
   logic                        w_empty;
   logic [bank_id_w_lp-1:0]     w_head;
   logic                        w_push;
   logic                        w_pop;
   logic                        w_wr_hs;
   logic                        w_rd_hs;
   logic                        w_wr_last;
   logic                        w_rd_last;

   assign w_full  = (r_fifo_occ == occ_w_lp'(reads_outstanding_p));
   assign w_empty = (r_fifo_occ == '0);
   assign w_head  = r_fifo[r_fifo_rptr];

   // A read is only eligible while the return FIFO has room, so a blocked read never stalls a write.
   for (genvar b = 0; b < num_banks_p; b++) begin : g_bank
      assign w_pkt[b]  = bank_dma_pkt_i[b*dma_pkt_width_lp +: dma_pkt_width_lp];
      assign w_elig[b] = (r_state == e_ready) & bank_dma_pkt_v_i[b]
                       & (w_pkt[b][dma_pkt_width_lp-1] | ~w_full);
      assign bank_dma_pkt_ready_and_o[b]  = w_pkt_hs & (w_gnt_id == bank_id_w_lp'(b));
      assign bank_dma_data_o[b*fill_width_p +: fill_width_p] = mem_dma_data_i;
      assign bank_dma_data_v_o[b]         = ~w_empty & mem_dma_data_v_i & (w_head == bank_id_w_lp'(b));
      assign bank_dma_data_ready_and_o[b] = (r_state == e_write) & mem_dma_data_ready_and_i
                                          & (r_wr_bank == bank_id_w_lp'(b));
   end

   // Descending scan: the last hit written is the one closest to the RR pointer.
   always_comb begin
      logic [idx_w_lp-1:0] idx;
      idx      = '0;
      w_gnt_v  = 1'b0;
      w_gnt_id = '0;
      for (int i = num_banks_p - 1; i >= 0; i--) begin
         idx = {1'b0, r_rr_ptr} + idx_w_lp'(i);
         if (idx >= idx_w_lp'(num_banks_p))
            idx = idx - idx_w_lp'(num_banks_p);
         if (w_elig[idx[bank_id_w_lp-1:0]]) begin
            w_gnt_v  = reset_n_i;
            w_gnt_id = idx[bank_id_w_lp-1:0];
         end
      end
   end

   assign mem_dma_pkt_o   = w_pkt[w_gnt_id];
   assign mem_dma_pkt_v_o = w_gnt_v;
   assign w_pkt_hs        = w_gnt_v & mem_dma_pkt_ready_and_i;
   assign w_gnt_write     = mem_dma_pkt_o[dma_pkt_width_lp-1];
   assign w_push          = w_pkt_hs & ~w_gnt_write;

   assign mem_dma_data_o   = bank_dma_data_i[r_wr_bank*fill_width_p +: fill_width_p];
   assign mem_dma_data_v_o = (r_state == e_write) & bank_dma_data_v_i[r_wr_bank];
   assign w_wr_hs          = mem_dma_data_v_o & mem_dma_data_ready_and_i;
   assign w_wr_last        = (r_wr_cnt == cnt_w_lp'(block_size_in_fills_p - 1));

   assign mem_dma_data_ready_and_o = ~w_empty & bank_dma_data_ready_and_i[w_head];
   assign w_rd_hs                  = mem_dma_data_v_i & mem_dma_data_ready_and_o;
   assign w_rd_last                = (r_rd_cnt == cnt_w_lp'(block_size_in_fills_p - 1));
   assign w_pop                    = w_rd_hs & w_rd_last;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= e_ready;
         r_rr_ptr  <= '0;
         r_wr_bank <= '0;
         r_wr_cnt  <= '0;
      end else begin
         case (r_state)
            e_ready: begin
               if (w_pkt_hs) begin
                  r_rr_ptr <= (w_gnt_id == bank_id_w_lp'(num_banks_p - 1)) ? '0 : w_gnt_id + 1'b1;
                  if (w_gnt_write) begin
                     r_wr_bank <= w_gnt_id;
                     r_state   <= e_write;
                  end
               end
            end
            e_write: begin
               if (w_wr_hs) begin
                  r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
                  if (w_wr_last)
                     r_state <= e_ready;
               end
            end
            default: r_state <= e_ready;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rd_cnt    <= '0;
         r_fifo_wptr <= '0;
         r_fifo_rptr <= '0;
         r_fifo_occ  <= '0;
         for (int i = 0; i < reads_outstanding_p; i++)
            r_fifo[i] <= '0;
      end else begin
         if (w_rd_hs)
            r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
         if (w_push) begin
            r_fifo[r_fifo_wptr] <= w_gnt_id;
            r_fifo_wptr <= (r_fifo_wptr == ptr_w_lp'(reads_outstanding_p - 1)) ? '0 : r_fifo_wptr + 1'b1;
         end
         if (w_pop)
            r_fifo_rptr <= (r_fifo_rptr == ptr_w_lp'(reads_outstanding_p - 1)) ? '0 : r_fifo_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fifo_occ <= r_fifo_occ + 1'b1;
            2'b01:   r_fifo_occ <= r_fifo_occ - 1'b1;
            default: r_fifo_occ <= r_fifo_occ;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_no_overflow:  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(w_push && w_full));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(w_pop && w_empty));
   a_state_known:  assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(r_state));
   a_stray_return: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(mem_dma_data_v_i && w_empty))
      else $warning("read return arrived with no outstanding read");
`endif

endmodule

// File: tb/tb_bp_me_cache_dma_mux.sv
// Directed bench for bp_me_cache_dma_mux with hand-computed expectations.
module tb_bp_me_cache_dma_mux;

   localparam logic [28:0] RD100 = 29'h0000100;
   localparam logic [28:0] RD200 = 29'h0000200;
   localparam logic [28:0] WR400 = {1'b1, 28'h0000400};
   localparam logic [28:0] WR440 = {1'b1, 28'h0000440};

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic [57:0]   bank_dma_pkt_i;
   logic [1:0]    bank_dma_pkt_v_i;
   logic [1:0]    bank_dma_pkt_ready_and_o;
   logic [127:0]  bank_dma_data_o;
   logic [1:0]    bank_dma_data_v_o;
   logic [1:0]    bank_dma_data_ready_and_i;
   logic [127:0]  bank_dma_data_i;
   logic [1:0]    bank_dma_data_v_i;
   logic [1:0]    bank_dma_data_ready_and_o;
   logic [28:0]   mem_dma_pkt_o;
   logic          mem_dma_pkt_v_o;
   logic          mem_dma_pkt_ready_and_i;
   logic [63:0]   mem_dma_data_i;
   logic          mem_dma_data_v_i;
   logic          mem_dma_data_ready_and_o;
   logic [63:0]   mem_dma_data_o;
   logic          mem_dma_data_v_o;
   logic          mem_dma_data_ready_and_i;

   int n_chk = 0;
   int n_bad = 0;

   bp_me_cache_dma_mux dut (
      .clk_i                     (clk_i),
      .reset_n_i                 (reset_n_i),
      .bank_dma_pkt_i            (bank_dma_pkt_i),
      .bank_dma_pkt_v_i          (bank_dma_pkt_v_i),
      .bank_dma_pkt_ready_and_o  (bank_dma_pkt_ready_and_o),
      .bank_dma_data_o           (bank_dma_data_o),
      .bank_dma_data_v_o         (bank_dma_data_v_o),
      .bank_dma_data_ready_and_i (bank_dma_data_ready_and_i),
      .bank_dma_data_i           (bank_dma_data_i),
      .bank_dma_data_v_i         (bank_dma_data_v_i),
      .bank_dma_data_ready_and_o (bank_dma_data_ready_and_o),
      .mem_dma_pkt_o             (mem_dma_pkt_o),
      .mem_dma_pkt_v_o           (mem_dma_pkt_v_o),
      .mem_dma_pkt_ready_and_i   (mem_dma_pkt_ready_and_i),
      .mem_dma_data_i            (mem_dma_data_i),
      .mem_dma_data_v_i          (mem_dma_data_v_i),
      .mem_dma_data_ready_and_o  (mem_dma_data_ready_and_o),
      .mem_dma_data_o            (mem_dma_data_o),
      .mem_dma_data_v_o          (mem_dma_data_v_o),
      .mem_dma_data_ready_and_i  (mem_dma_data_ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here, outputs checked 1ns later.
   task automatic cyc;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_all_idle(input string tag);
      chk({tag, "_pkt_v"},   64'(mem_dma_pkt_v_o), 64'd0);
      chk({tag, "_pkt_rdy"}, 64'(bank_dma_pkt_ready_and_o), 64'd0);
      chk({tag, "_wd_v"},    64'(mem_dma_data_v_o), 64'd0);
      chk({tag, "_wd_rdy"},  64'(bank_dma_data_ready_and_o), 64'd0);
      chk({tag, "_rd_rdy"},  64'(mem_dma_data_ready_and_o), 64'd0);
      chk({tag, "_fill_v"},  64'(bank_dma_data_v_o), 64'd0);
   endtask

   initial begin
      reset_n_i                 = 1'b0;
      bank_dma_pkt_i            = {RD200, RD100};
      bank_dma_pkt_v_i          = 2'b11;
      bank_dma_data_ready_and_i = 2'b11;
      bank_dma_data_i           = '0;
      bank_dma_data_v_i         = 2'b00;
      mem_dma_pkt_ready_and_i   = 1'b1;
      mem_dma_data_i            = '0;
      mem_dma_data_v_i          = 1'b0;
      mem_dma_data_ready_and_i  = 1'b1;

      // Reset holds every valid/ready low even with requests pending.
      cyc; cyc;
      #1;
      chk_all_idle("reset");

      // Round robin between two continuous readers: 0,1,0,1 fills the 4-entry FIFO.
      reset_n_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_v",   64'(mem_dma_pkt_v_o), 64'd1);
         chk("rr_pkt", 64'(mem_dma_pkt_o), (k % 2 == 1) ? 64'(RD200) : 64'(RD100));
         chk("rr_rdy", 64'(bank_dma_pkt_ready_and_o), (k % 2 == 1) ? 64'd2 : 64'd1);
         cyc;
      end

      // FIFO full: reads blocked, but a write from bank 1 is still granted.
      #1;
      chk("full_v",   64'(mem_dma_pkt_v_o), 64'd0);
      chk("full_rdy", 64'(bank_dma_pkt_ready_and_o), 64'd0);
      bank_dma_pkt_i = {WR400, RD100};
      #1;
      chk("wgnt_v",   64'(mem_dma_pkt_v_o), 64'd1);
      chk("wgnt_pkt", 64'(mem_dma_pkt_o), 64'(WR400));
      chk("wgnt_rdy", 64'(bank_dma_pkt_ready_and_o), 64'd2);
      cyc;

      // Write beats A0..A7 from bank 1 with concurrent read returns B0..B7 to bank 0.
      bank_dma_pkt_v_i  = 2'b01;
      bank_dma_data_v_i = 2'b11;
      mem_dma_data_v_i  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bank_dma_data_i = {64'hA0 + 64'(k), 64'hDEAD};
         mem_dma_data_i  = 64'hB0 + 64'(k);
         #1;
         chk("wr_dat",    mem_dma_data_o, 64'hA0 + 64'(k));
         chk("wr_v",      64'(mem_dma_data_v_o), 64'd1);
         chk("wr_rdy",    64'(bank_dma_data_ready_and_o), 64'd2);
         chk("lock_pkt_v", 64'(mem_dma_pkt_v_o), 64'd0);
         chk("lock_rdy",  64'(bank_dma_pkt_ready_and_o), 64'd0);
         chk("cc_fill_v", 64'(bank_dma_data_v_o), 64'd1);
         chk("cc_fill_d", bank_dma_data_o[63:0], 64'hB0 + 64'(k));
         chk("cc_rd_rdy", 64'(mem_dma_data_ready_and_o), 64'd1);
         cyc;
      end

      // Block done and one entry popped: bank 0's read goes now; bank 0 data is not forwarded.
      mem_dma_data_v_i = 1'b0;
      #1;
      chk("after_v",    64'(mem_dma_pkt_v_o), 64'd1);
      chk("after_pkt",  64'(mem_dma_pkt_o), 64'(RD100));
      chk("after_rdy",  64'(bank_dma_pkt_ready_and_o), 64'd1);
      chk("nogrant_wv", 64'(mem_dma_data_v_o), 64'd0);
      chk("nogrant_wr", 64'(bank_dma_data_ready_and_o), 64'd0);
      cyc;

      // FIFO now 1,0,1,0: bank 1 stalls 3 cycles, then takes 8 beats, then head moves to bank 0.
      bank_dma_pkt_v_i          = 2'b00;
      bank_dma_data_v_i         = 2'b00;
      bank_dma_data_ready_and_i = 2'b01;
      mem_dma_data_v_i          = 1'b1;
      mem_dma_data_i            = 64'hC0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_fill_v", 64'(bank_dma_data_v_o), 64'd2);
         chk("stall_rd_rdy", 64'(mem_dma_data_ready_and_o), 64'd0);
         cyc;
      end
      bank_dma_data_ready_and_i = 2'b11;
      for (int k = 0; k < 8; k++) begin
         mem_dma_data_i = 64'hC0 + 64'(k);
         #1;
         chk("b1_fill_v", 64'(bank_dma_data_v_o), 64'd2);
         chk("b1_rd_rdy", 64'(mem_dma_data_ready_and_o), 64'd1);
         chk("b1_fill_d", bank_dma_data_o[127:64], 64'hC0 + 64'(k));
         cyc;
      end
      mem_dma_data_i = 64'hD0;
      #1;
      chk("b0_fill_v", 64'(bank_dma_data_v_o), 64'd1);
      mem_dma_data_v_i = 1'b0;

      // Bank 0 write; reset asserted during beat 3 while the RR pointer sits at 1.
      bank_dma_pkt_i   = {RD200, WR440};
      bank_dma_pkt_v_i = 2'b01;
      #1;
      chk("w0_pkt", 64'(mem_dma_pkt_o), 64'(WR440));
      chk("w0_v",   64'(mem_dma_pkt_v_o), 64'd1);
      cyc;
      bank_dma_pkt_v_i  = 2'b00;
      bank_dma_data_v_i = 2'b01;
      for (int k = 0; k < 3; k++) begin
         bank_dma_data_i = {64'h0, 64'hE0 + 64'(k)};
         #1;
         chk("w0_dat", mem_dma_data_o, 64'hE0 + 64'(k));
         cyc;
      end
      bank_dma_data_i = {64'h0, 64'hE3};
      #1;
      chk("w0_beat3_v", 64'(mem_dma_data_v_o), 64'd1);
      bank_dma_pkt_i   = {RD200, RD100};
      bank_dma_pkt_v_i = 2'b11;
      reset_n_i        = 1'b0;
      #1;
      chk_all_idle("midrst");
      cyc;

      // After release: e_ready, RR pointer back at bank 0, FIFO empty.
      reset_n_i = 1'b1;
      #1;
      chk("post_pkt_v", 64'(mem_dma_pkt_v_o), 64'd1);
      chk("post_pkt",   64'(mem_dma_pkt_o), 64'(RD100));
      chk("post_rdy",   64'(bank_dma_pkt_ready_and_o), 64'd1);
      chk("post_wd_v",  64'(mem_dma_data_v_o), 64'd0);
      chk("post_rd_rdy", 64'(mem_dma_data_ready_and_o), 64'd0);
      bank_dma_pkt_v_i = 2'b00;
      cyc;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
